// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared UART definitions (frame width, baud divider
//               derivation, receiver FSM encoding). The transmit side
//               derives its divider through the same helpers so that a
//               uart_tx / uart_rx pair always agrees on bit timing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Data bits per 8N1 frame
  localparam int DATA_BITS = 8;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clock cycles per bit; the truncation error is accepted, not compensated
  function automatic int calc_div(input int freq, input int rate);
    return freq / rate;
  endfunction

  // Cycles from the detected start edge to the middle of the start bit
  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop metastability synchroniser for asynchronous input
//               pins. Both stages reset to RESET_VAL so an idle-high line
//               looks idle straight out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; only sync_q is safe to use downstream
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Detects the start edge on the
//               synchronised line, samples every bit at its centre, and
//               presents each good byte with a one-cycle o_valid strobe.
//               A low stop bit raises a one-cycle o_frame_err strobe and
//               discards the byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FREQ = 50_000_000,
  parameter int RATE = 115_200
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int DIV  = calc_div(FREQ, RATE);
  localparam int HALF = calc_half(DIV);
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .CLK   (CLK),
    .rst_n (rst_n),
    .d_i   (i_rx),
    .q_o   (rx_s)
  );

  // Next-state logic: the counter restarts from zero on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A start edge only counts once the line has been seen high, so a
        // line held low (break, post-reset mid-frame) never retriggers.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            // Line back high at mid start bit: a glitch, not a frame
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == C_BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end

      ST_STOP: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and output strobe registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule : uart_rx
`default_nettype wire
